// File: rtl/dual_registered_adder_unit.sv
// Two registered full-adder paths (1-cycle and 2-cycle latency) plus a plain D flip-flop.
// Optional path cross-check enabled by defining ADDER_XCHECK_EN; otherwise mismatch is constant 0.
module dual_registered_adder_unit #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             d,
    output logic [WIDTH-1:0] sum_1,
    output logic             carry_out_1,
    output logic [WIDTH-1:0] sum_2,
    output logic             carry_out_2,
    output logic             q,
    output logic             q_bar,
    output logic             mismatch
);

    logic [WIDTH:0]   w_full_1;
    logic [WIDTH:0]   w_full_2;
    logic [WIDTH-1:0] r_sum_1;
    logic             r_carry_1;
    logic [WIDTH-1:0] r_a_2;
    logic [WIDTH-1:0] r_b_2;
    logic             r_cin_2;
    logic [WIDTH-1:0] r_sum_2;
    logic             r_carry_2;
    logic             r_q;

    // Both adders work at WIDTH+1 bits so overflow lands in the carry bit.
    assign w_full_1 = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_in};
    assign w_full_2 = {1'b0, r_a_2} + {1'b0, r_b_2} + {{WIDTH{1'b0}}, r_cin_2};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sum_1   <= '0;
            r_carry_1 <= 1'b0;
        end else begin
            {r_carry_1, r_sum_1} <= w_full_1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a_2     <= '0;
            r_b_2     <= '0;
            r_cin_2   <= 1'b0;
            r_sum_2   <= '0;
            r_carry_2 <= 1'b0;
        end else begin
            r_a_2                <= a;
            r_b_2                <= b;
            r_cin_2              <= carry_in;
            {r_carry_2, r_sum_2} <= w_full_2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= 1'b0;
        end else begin
            r_q <= d;
        end
    end

    assign sum_1       = r_sum_1;
    assign carry_out_1 = r_carry_1;
    assign sum_2       = r_sum_2;
    assign carry_out_2 = r_carry_2;
    assign q           = r_q;
    assign q_bar       = ~r_q;

`ifdef ADDER_XCHECK_EN
    logic [WIDTH:0] r_p1_dly;
    logic [1:0]     r_warm;
    logic           r_mismatch;

    // Path 2 lags path 1 by one edge, so compare it against path 1 delayed once;
    // the first two edges after release carry flushed data and are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p1_dly   <= '0;
            r_warm     <= 2'd0;
            r_mismatch <= 1'b0;
        end else begin
            r_p1_dly <= {r_carry_1, r_sum_1};
            if (r_warm != 2'd2) begin
                r_warm <= r_warm + 2'd1;
            end else if ({r_carry_2, r_sum_2} != r_p1_dly) begin
                r_mismatch <= 1'b1;
            end
        end
    end

    assign mismatch = r_mismatch;
`else
    assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_dual_registered_adder_unit.sv
// Bench for dual_registered_adder_unit: WIDTH=1 and WIDTH=8 instances driven side by side,
// table-driven vectors plus reset / mid-operation reset / random sequences, queue scoreboard.
module tb_dual_registered_adder_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       c1 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       c8 = 1'b0;
  logic       d = 1'b0;

  logic [0:0] s1_1, s2_1;
  logic       co1_1, co2_1, q_1, qb_1, mm_1;
  logic [7:0] s1_8, s2_8;
  logic       co1_8, co2_8, q_8, qb_8, mm_8;

  int n_checks = 0;
  int n_errors = 0;

  // scoreboard queues: path 1, path 2 and flip-flop expectations
  logic [1:0] exp1_p1_q[$];
  logic [1:0] exp1_p2_q[$];
  logic [8:0] exp8_p1_q[$];
  logic [8:0] exp8_p2_q[$];
  logic       expd_q[$];

  typedef struct {
    logic       a1, b1, c1;
    logic [1:0] e1;
    logic [7:0] a8, b8;
    logic       c8;
    logic [8:0] e8;
    logic       d;
  } vec_t;

  vec_t vecs[8];

  dual_registered_adder_unit #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .carry_in(c1), .d(d),
    .sum_1(s1_1), .carry_out_1(co1_1), .sum_2(s2_1), .carry_out_2(co2_1),
    .q(q_1), .q_bar(qb_1), .mismatch(mm_1)
  );

  dual_registered_adder_unit #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .carry_in(c8), .d(d),
    .sum_1(s1_8), .carry_out_1(co1_8), .sum_2(s2_8), .carry_out_2(co2_8),
    .q(q_8), .q_bar(qb_8), .mismatch(mm_8)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    n_errors++;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " w1 p1"}, {co1_1, s1_1}, 0);
    check({tag, " w1 p2"}, {co2_1, s2_1}, 0);
    check({tag, " w8 p1"}, {co1_8, s1_8}, 0);
    check({tag, " w8 p2"}, {co2_8, s2_8}, 0);
    check({tag, " q"}, {q_1, q_8}, 0);
    check({tag, " q_bar"}, {qb_1, qb_8}, 2'b11);
    check({tag, " mismatch"}, {mm_1, mm_8}, 0);
  endtask

  task automatic clear_sb();
    exp1_p1_q.delete(); exp1_p2_q.delete();
    exp8_p1_q.delete(); exp8_p2_q.delete();
    expd_q.delete();
  endtask

  // release at a falling edge; path 2 first shows the sum of its reset-zero input registers
  task automatic release_reset();
    clear_sb();
    rst_n = 1'b1;
    exp1_p2_q.push_back(2'b00);
    exp8_p2_q.push_back(9'h000);
  endtask

  // drive one cycle of stimulus, push expectations, take the edge, compare at the falling edge
  task automatic step(input logic ia1, input logic ib1, input logic ic1, input logic [1:0] ie1,
                      input logic [7:0] ia8, input logic [7:0] ib8, input logic ic8,
                      input logic [8:0] ie8, input logic id);
    logic [1:0] e1;
    logic [8:0] e8;
    logic       ed;
    a1 = ia1; b1 = ib1; c1 = ic1;
    a8 = ia8; b8 = ib8; c8 = ic8;
    d = id;
    exp1_p1_q.push_back(ie1); exp1_p2_q.push_back(ie1);
    exp8_p1_q.push_back(ie8); exp8_p2_q.push_back(ie8);
    expd_q.push_back(id);
    @(posedge clk);
    @(negedge clk);
    if (exp1_p1_q.size() == 0 || exp1_p2_q.size() == 0 || exp8_p1_q.size() == 0 ||
        exp8_p2_q.size() == 0 || expd_q.size() == 0) begin
      check("scoreboard empty", 1, 0);
    end else begin
      e1 = exp1_p1_q.pop_front(); check("w1 path1", {co1_1, s1_1}, e1);
      e1 = exp1_p2_q.pop_front(); check("w1 path2", {co2_1, s2_1}, e1);
      e8 = exp8_p1_q.pop_front(); check("w8 path1", {co1_8, s1_8}, e8);
      e8 = exp8_p2_q.pop_front(); check("w8 path2", {co2_8, s2_8}, e8);
      ed = expd_q.pop_front();
      check("q", {q_1, q_8}, {ed, ed});
      check("q_bar", {qb_1, qb_8}, {~ed, ~ed});
      check("mismatch", {mm_1, mm_8}, 0);
    end
  endtask

  task automatic random_step();
    logic       ra1, rb1, rc1, rc8, rd;
    logic [7:0] ra8, rb8;
    logic [8:0] e8;
    logic [1:0] e1;
    ra1 = 1'($urandom_range(0, 1)); rb1 = 1'($urandom_range(0, 1));
    rc1 = 1'($urandom_range(0, 1)); rc8 = 1'($urandom_range(0, 1));
    rd  = 1'($urandom_range(0, 1));
    ra8 = 8'($urandom_range(0, 255)); rb8 = 8'($urandom_range(0, 255));
    e1 = {1'b0, ra1} + {1'b0, rb1} + {1'b0, rc1};
    e8 = {1'b0, ra8} + {1'b0, rb8} + {8'd0, rc8};
    step(ra1, rb1, rc1, e1, ra8, rb8, rc8, e8, rd);
  endtask

  initial begin
    // WIDTH=1 truth table alongside WIDTH=8 boundary vectors; d follows 0,1,0,0,1,...
    vecs[0] = '{1'b0, 1'b0, 1'b0, 2'b00, 8'hFF, 8'h01, 1'b0, 9'h100, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 2'b01, 8'h7F, 8'h80, 1'b1, 9'h100, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 2'b01, 8'h00, 8'h00, 1'b0, 9'h000, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 2'b10, 8'h12, 8'h34, 1'b1, 9'h047, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 1'b0, 2'b01, 8'hFF, 8'hFF, 1'b1, 9'h1FF, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 2'b10, 8'h80, 8'h80, 1'b0, 9'h100, 1'b1};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 2'b10, 8'h55, 8'hAA, 1'b0, 9'h0FF, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 2'b11, 8'h01, 8'h02, 1'b1, 9'h004, 1'b1};

    // reset held with all inputs high and the clock running
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1; d = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_all_zero("in reset");
    end

    // first edge after release: path 1 shows 1+1+1, path 2 still shows zero
    release_reset();
    step(1'b1, 1'b1, 1'b1, 2'b11, 8'hFF, 8'h01, 1'b0, 9'h100, 1'b1);

    for (int i = 0; i < 8; i++) begin
      step(vecs[i].a1, vecs[i].b1, vecs[i].c1, vecs[i].e1,
           vecs[i].a8, vecs[i].b8, vecs[i].c8, vecs[i].e8, vecs[i].d);
    end

    for (int i = 0; i < 10; i++) random_step();

    // leave nonzero data in both pipeline stages, then reset between edges
    step(1'b1, 1'b1, 1'b0, 2'b10, 8'h7F, 8'h80, 1'b1, 9'h100, 1'b1);
    step(1'b1, 1'b0, 1'b1, 2'b10, 8'hF0, 8'h0F, 1'b0, 9'h0FF, 1'b1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async reset");
    @(negedge clk);
    check_all_zero("reset hold");

    release_reset();
    for (int i = 0; i < 30; i++) random_step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
